alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: port A (integer execute pipe) and port B (address/branch-target helper).
- Per cycle it accepts at most one request via a valid/ready handshake and drives the ALU's v1/v2/instructions inputs.
- It captures the ALU result into a one-entry registered output stage that has its own valid/ready handshake.
- It sits between decode/issue and writeback/AGU consumers.

Parameters:
- XLEN, 32, operand/result width
- OPW, 47, one-hot instruction vector width (matches the ALU instructions input)
- TAGW, 5, requester tag width (destination register index or AGU slot)
- OPMASK, 47'h1FFFF, instruction bits the ALU executes; any other set bit is illegal

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- a_valid  in  1  port A request valid
- a_ready  out  1  port A request accepted this cycle
- a_instr  in  OPW  port A one-hot opcode
- a_op1  in  XLEN  port A operand 1
- a_op2  in  XLEN  port A operand 2 (rs2 or immediate, selected upstream)
- a_tag  in  TAGW  port A tag
- b_valid, b_ready, b_instr, b_op1, b_op2, b_tag  same as port A, for port B
- alu_v1  out  XLEN  to ALU v1
- alu_v2  out  XLEN  to ALU v2
- alu_instr  out  OPW  to ALU instructions
- alu_result  in  XLEN  from ALU ALUoutput (combinational)
- res_valid  out  1  result register holds data
- res_ready  in  1  consumer accepts result
- res_data  out  XLEN  registered result
- res_src  out  1  0 = port A, 1 = port B
- res_tag  out  TAGW  tag of the granted request
- res_illegal  out  1  granted opcode was not exactly one-hot within OPMASK; res_data forced to 0
- busy_cnt  out  16  saturating count of cycles in which any request was valid but not accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - res_valid=0, res_data=0, res_src=0, res_tag=0, res_illegal=0, busy_cnt=0.
  - Round-robin pointer = A (A has priority on the first contention).
  - a_ready and b_ready are 0 in the reset cycle.
  - An in-flight result is discarded.
- Clock and reset: single clock; reset is synchronous and active-high.
- Output-stage enable: free = !res_valid || res_ready (combinational).
- Grant (combinational, only when free=1 and rst=0):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the side the pointer names.
  - The pointer flips to the other side only after a grant made under contention.
  - A single-requester grant does not move the pointer.
- Ready outputs: a_ready = grant_A, b_ready = grant_B. Never both high. Both are 0 when free=0.
  - Ready may depend on valid; requesters must not make valid depend on ready.
- ALU drive:
  - alu_v1/alu_v2/alu_instr = the granted port's fields.
  - With no grant, the port A fields are driven with alu_instr forced to 0, which gives ALU output 0.
- Capture (latency 1): on a grant, the next edge loads:
  - res_valid=1
  - res_data=alu_result, or 0 if illegal
  - res_src, res_tag
  - res_illegal = !(instr nonzero && one-hot && (instr & ~OPMASK)==0)
- Hold and pass-through:
  - If res_valid && !res_ready, all res_* outputs hold and no grant occurs (backpressure).
  - If res_valid && res_ready with no new grant, res_valid clears next edge; res_data holds its value.
  - Simultaneous consume and grant in the same cycle gives back-to-back results, one per clock, with no bubble.
- busy_cnt increments when (a_valid && !a_ready) || (b_valid && !b_ready) and saturates at 16'hFFFF.
- Requester stability: a requester holding valid=1 keeps its fields stable until ready.
- Fairness: under continuous contention and res_ready=1, grants strictly alternate A,B,A,B.

Decomposition:
- Shared package alu_pkg:
  - XLEN and OPW constants.
  - One-hot opcode constants: ADD=1, SUB=2, XOR=4, OR=8, AND=16, SLL=32, SRL=64, SRA=128, SLT=256, SLTU=512, plus the immediate forms 0x400–0x10000.
  - OPMASK.
- One natural sub-module: alu_onehot_chk, a combinational legality check (nonzero, one-hot, within mask).
- Arbitration, pointer, output register and counter stay in alu_arbiter.

Test Plan:
- Reset then idle: rst high 2 cycles -> all res_* = 0, a_ready=b_ready=0 during reset, busy_cnt=0.
- Single A request: ADD (0x1), op1=5, op2=7, tag=3, res_ready=1 -> a_ready=1 in cycle 0; next cycle res_valid=1, res_data=12, res_src=0, res_tag=3.
- Contention: A SUB 10-3 (tag 1) and B XOR 0xF0^0x0F (tag 2), both held valid, res_ready=1 -> A result 7 first, then B result 0xFF, then A again; grants alternate.
- Backpressure: result pending with res_ready=0 for 3 cycles and A valid -> a_ready=0 throughout, res_* stable, busy_cnt=3. Raise res_ready -> A granted that same cycle, back-to-back result next edge.
- Illegal opcode: B instr=0x3 (two bits set) -> b_ready=1, res_illegal=1, res_data=0. Then instr=47'h20000 (outside mask) -> res_illegal=1.
- Reset mid-operation: res_valid=1 with res_ready=0, assert rst one cycle -> next edge res_valid=0, pointer back to A. With both requesters valid afterwards, A is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and one-hot opcode encodings for the execute-stage ALU and its arbiter.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 47;
  localparam int TAGW = 5;

  // Register-register forms
  localparam logic [OPW-1:0] OP_ADD  = 47'h00001;
  localparam logic [OPW-1:0] OP_SUB  = 47'h00002;
  localparam logic [OPW-1:0] OP_XOR  = 47'h00004;
  localparam logic [OPW-1:0] OP_OR   = 47'h00008;
  localparam logic [OPW-1:0] OP_AND  = 47'h00010;
  localparam logic [OPW-1:0] OP_SLL  = 47'h00020;
  localparam logic [OPW-1:0] OP_SRL  = 47'h00040;
  localparam logic [OPW-1:0] OP_SRA  = 47'h00080;
  localparam logic [OPW-1:0] OP_SLT  = 47'h00100;
  localparam logic [OPW-1:0] OP_SLTU = 47'h00200;

  // Immediate forms; operand 2 already carries the immediate
  localparam logic [OPW-1:0] OP_ADDI = 47'h00400;
  localparam logic [OPW-1:0] OP_XORI = 47'h00800;
  localparam logic [OPW-1:0] OP_ORI  = 47'h01000;
  localparam logic [OPW-1:0] OP_ANDI = 47'h02000;
  localparam logic [OPW-1:0] OP_SLLI = 47'h04000;
  localparam logic [OPW-1:0] OP_SRLI = 47'h08000;
  localparam logic [OPW-1:0] OP_SRAI = 47'h10000;

  localparam logic [OPW-1:0] OPMASK = 47'h1FFFF;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

endpackage

// File: rtl/alu_onehot_chk.sv
// Combinational opcode legality: nonzero, exactly one bit set, and no bit outside the executable mask.
module alu_onehot_chk
  import alu_pkg::*;
#(
  parameter int              OPW    = alu_pkg::OPW,
  parameter logic [OPW-1:0]  OPMASK = alu_pkg::OPMASK
) (
  input  logic [OPW-1:0] instr,
  output logic           legal
);

  localparam logic [OPW-1:0] ONE = {{(OPW-1){1'b0}}, 1'b1};

  logic [OPW-1:0] outside;
  logic           nonzero;
  logic           single;

  for (genvar gi = 0; gi < OPW; gi++) begin : g_mask
    assign outside[gi] = instr[gi] && !OPMASK[gi];
  end

  assign nonzero = |instr;
  // Clearing the lowest set bit leaves zero only when one bit was set
  assign single  = ((instr & (instr - ONE)) == '0);
  assign legal   = nonzero && single && !(|outside);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry registered result stage and a saturating stall counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int              XLEN   = alu_pkg::XLEN,
  parameter int              OPW    = alu_pkg::OPW,
  parameter int              TAGW   = alu_pkg::TAGW,
  parameter logic [OPW-1:0]  OPMASK = alu_pkg::OPMASK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [OPW-1:0]  a_instr,
  input  logic [XLEN-1:0] a_op1,
  input  logic [XLEN-1:0] a_op2,
  input  logic [TAGW-1:0] a_tag,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [OPW-1:0]  b_instr,
  input  logic [XLEN-1:0] b_op1,
  input  logic [XLEN-1:0] b_op2,
  input  logic [TAGW-1:0] b_tag,
  output logic [XLEN-1:0] alu_v1,
  output logic [XLEN-1:0] alu_v2,
  output logic [OPW-1:0]  alu_instr,
  input  logic [XLEN-1:0] alu_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_src,
  output logic [TAGW-1:0] res_tag,
  output logic            res_illegal,
  output logic [15:0]     busy_cnt
);

  side_t           ptr_reg;
  logic            res_valid_reg;
  logic [XLEN-1:0] res_data_reg;
  logic            res_src_reg;
  logic [TAGW-1:0] res_tag_reg;
  logic            res_illegal_reg;
  logic [15:0]     busy_cnt_reg;
  logic [15:0]     busy_cnt_next;

  logic            free;
  logic            contention;
  logic            grant_a;
  logic            grant_b;
  logic            grant;
  logic            stalled;
  logic            legal;
  logic [TAGW-1:0] sel_tag;

  assign free       = !res_valid_reg || res_ready;
  assign contention = a_valid && b_valid;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && free) begin
      if (contention) begin
        grant_a = (ptr_reg == SIDE_A);
        grant_b = (ptr_reg == SIDE_B);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign grant   = grant_a || grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Idle cycles present port A operands with a zero opcode so the ALU outputs 0
  assign alu_v1    = grant_b ? b_op1 : a_op1;
  assign alu_v2    = grant_b ? b_op2 : a_op2;
  assign alu_instr = grant_b ? b_instr : (grant_a ? a_instr : '0);
  assign sel_tag   = grant_b ? b_tag : a_tag;

  alu_onehot_chk #(
    .OPW    (OPW),
    .OPMASK (OPMASK)
  ) u_chk (
    .instr (alu_instr),
    .legal (legal)
  );

  assign stalled       = (a_valid && !grant_a) || (b_valid && !grant_b);
  assign busy_cnt_next = (stalled && (busy_cnt_reg != 16'hFFFF)) ? busy_cnt_reg + 16'd1
                                                                  : busy_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= SIDE_A;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
      res_src_reg     <= 1'b0;
      res_tag_reg     <= '0;
      res_illegal_reg <= 1'b0;
      busy_cnt_reg    <= '0;
    end else begin
      busy_cnt_reg <= busy_cnt_next;
      if (grant) begin
        res_valid_reg   <= 1'b1;
        res_data_reg    <= legal ? alu_result : '0;
        res_src_reg     <= grant_b;
        res_tag_reg     <= sel_tag;
        res_illegal_reg <= !legal;
        // Only a contended grant hands priority to the other side
        if (contention) begin
          ptr_reg <= (ptr_reg == SIDE_A) ? SIDE_B : SIDE_A;
        end
      end else if (res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign res_src     = res_src_reg;
  assign res_tag     = res_tag_reg;
  assign res_illegal = res_illegal_reg;
  assign busy_cnt    = busy_cnt_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model and a behavioural ALU stub.
module tb_alu_arbiter;

  localparam logic [46:0] MASK = 47'h1FFFF;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [46:0] a_instr, b_instr;
  logic [31:0] a_op1, a_op2, b_op1, b_op2;
  logic [4:0]  a_tag, b_tag;
  logic [31:0] alu_v1, alu_v2;
  logic [46:0] alu_instr;
  logic [31:0] alu_result;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_src;
  logic [4:0]  res_tag;
  logic        res_illegal;
  logic [15:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: pending result, whose turn it is under contention, stall count
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_src = 1'b0;
  logic [4:0]  m_tag = '0;
  logic        m_ill = 1'b0;
  logic        m_turn_b = 1'b0;
  int          m_busy = 0;
  logic        exp_ga, exp_gb;
  logic        last_ga = 1'b0, last_gb = 1'b0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr), .a_op1(a_op1), .a_op2(a_op2), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr), .b_op1(b_op1), .b_op2(b_op2), .b_tag(b_tag),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_instr(alu_instr), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src),
    .res_tag(res_tag), .res_illegal(res_illegal), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [46:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      47'h0:              return 32'd0;
      47'h1, 47'h400:     return x + y;
      47'h2:              return x - y;
      47'h4, 47'h800:     return x ^ y;
      47'h8, 47'h1000:    return x | y;
      47'h10, 47'h2000:   return x & y;
      47'h20, 47'h4000:   return x << y[4:0];
      47'h40, 47'h8000:   return x >> y[4:0];
      47'h80, 47'h10000:  return $unsigned($signed(x) >>> y[4:0]);
      47'h100:            return {31'd0, $signed(x) < $signed(y)};
      47'h200:            return {31'd0, x < y};
      default:            return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic is_legal(input logic [46:0] op);
    return ($countones(op) == 1) && ((op & ~MASK) == 47'd0);
  endfunction

  function automatic logic [46:0] rand_op();
    int k;
    logic [46:0] one;
    one = 47'd1;
    k = $urandom_range(0, 19);
    if (k < 17) return one << $urandom_range(0, 16);
    if (k == 17) return 47'd0;
    if (k == 18) return one << $urandom_range(17, 46);
    return (one << $urandom_range(0, 7)) | (one << $urandom_range(8, 16));
  endfunction

  // External ALU behaviour
  always_comb alu_result = ref_alu(alu_instr, alu_v1, alu_v2);

  task automatic predict();
    logic free;
    free = !m_valid || res_ready;
    exp_ga = 1'b0;
    exp_gb = 1'b0;
    if (!rst && free) begin
      if (a_valid && b_valid) begin
        if (m_turn_b) exp_gb = 1'b1;
        else          exp_ga = 1'b1;
      end else if (a_valid) begin
        exp_ga = 1'b1;
      end else if (b_valid) begin
        exp_gb = 1'b1;
      end
    end
  endtask

  // Advance the model by one transaction-level step, then the clock
  task automatic tick();
    logic [46:0] op;
    logic [31:0] x, y;
    predict();
    last_ga = exp_ga;
    last_gb = exp_gb;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_tag = '0; m_ill = 1'b0;
      m_turn_b = 1'b0; m_busy = 0;
    end else begin
      if ((a_valid && !exp_ga) || (b_valid && !exp_gb)) begin
        if (m_busy < 65535) m_busy++;
      end
      if (exp_ga || exp_gb) begin
        op = exp_gb ? b_instr : a_instr;
        x  = exp_gb ? b_op1 : a_op1;
        y  = exp_gb ? b_op2 : a_op2;
        m_valid = 1'b1;
        m_ill   = !is_legal(op);
        m_data  = m_ill ? 32'd0 : ref_alu(op, x, y);
        m_src   = exp_gb;
        m_tag   = exp_gb ? b_tag : a_tag;
        if (a_valid && b_valid) m_turn_b = !m_turn_b;
        $display("xfer t=%0t src=%0d tag=%0d op=%h data=%h ill=%0b", $time, m_src, m_tag, op, m_data, m_ill);
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; res_ready = 1'b1;
    a_valid = 1'b1; a_instr = 47'h1; a_op1 = 32'd1; a_op2 = 32'd2; a_tag = 5'd1;
    b_valid = 1'b1; b_instr = 47'h2; b_op1 = 32'd3; b_op2 = 32'd4; b_tag = 5'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
        errors++; $display("FAIL reset_ready cyc=%0d got=%b want=00", i, {a_ready, b_ready});
      end
      tick();
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_data, res_src, res_tag, res_illegal} !== 40'd0) begin
      errors++; $display("FAIL reset_res got v=%0b d=%h s=%0b t=%0d i=%0b want all 0",
                         res_valid, res_data, res_src, res_tag, res_illegal);
    end
    checks++;
    if (busy_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_busy got=%0d want=0", busy_cnt);
    end
  endtask

  task automatic test_single_a();
    res_ready = 1'b1;
    a_valid = 1'b1; a_instr = 47'h1; a_op1 = 32'd5; a_op2 = 32'd7; a_tag = 5'd3;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got=%b want=10", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if ({res_valid, res_data, res_src, res_tag, res_illegal} !== {1'b1, 32'd12, 1'b0, 5'd3, 1'b0}) begin
      errors++; $display("FAIL single_res got v=%0b d=%0d s=%0b t=%0d want v=1 d=12 s=0 t=3",
                         res_valid, res_data, res_src, res_tag);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  want_rdy [3];
    logic [31:0] want_dat [3];
    want_rdy = '{2'b10, 2'b01, 2'b10};
    want_dat = '{32'd7, 32'hFF, 32'd7};
    res_ready = 1'b1;
    a_valid = 1'b1; a_instr = 47'h2; a_op1 = 32'd10;   a_op2 = 32'd3;   a_tag = 5'd1;
    b_valid = 1'b1; b_instr = 47'h4; b_op1 = 32'hF0;  b_op2 = 32'h0F;  b_tag = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== want_rdy[i]) begin
        errors++; $display("FAIL contend_ready n=%0d got=%b want=%b", i, {a_ready, b_ready}, want_rdy[i]);
      end
      tick();
      checks++;
      if ({res_valid, res_data, res_src} !== {1'b1, want_dat[i], want_rdy[i][0]}) begin
        errors++; $display("FAIL contend_res n=%0d got v=%0b d=%h s=%0b want v=1 d=%h s=%0b",
                           i, res_valid, res_data, res_src, want_dat[i], want_rdy[i][0]);
      end
    end
    checks++;
    if (busy_cnt !== 16'(m_busy)) begin
      errors++; $display("FAIL contend_busy got=%0d want=%0d", busy_cnt, m_busy);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [39:0] held;
    int          busy_before;
    held = {m_valid, m_data, m_src, m_tag, m_ill};
    busy_before = m_busy;
    res_ready = 1'b0;
    a_valid = 1'b1; a_instr = 47'h400; a_op1 = 32'd100; a_op2 = 32'd23; a_tag = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cyc=%0d got=%b want=0", i, a_ready);
      end
      tick();
      checks++;
      if ({res_valid, res_data, res_src, res_tag, res_illegal} !== held) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i,
                           {res_valid, res_data, res_src, res_tag, res_illegal}, held);
      end
    end
    checks++;
    if (busy_cnt !== 16'(busy_before + 3)) begin
      errors++; $display("FAIL bp_busy got=%0d want=%0d", busy_cnt, busy_before + 3);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got=%b want=1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if ({res_valid, res_data, res_src, res_tag, res_illegal} !== {1'b1, 32'd123, 1'b0, 5'd9, 1'b0}) begin
      errors++; $display("FAIL bp_release_res got v=%0b d=%0d t=%0d want v=1 d=123 t=9",
                         res_valid, res_data, res_tag);
    end
  endtask

  task automatic test_illegal();
    logic [46:0] ops [2];
    ops = '{47'h3, 47'h20000};
    res_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_valid = 1'b1; b_instr = ops[i]; b_op1 = 32'd1; b_op2 = 32'd2; b_tag = 5'(4 + i);
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_ready n=%0d got=%b want=1", i, b_ready);
      end
      tick();
      checks++;
      if ({res_valid, res_illegal, res_data, res_src} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
        errors++; $display("FAIL illegal_res n=%0d got v=%0b ill=%0b d=%h s=%0b want v=1 ill=1 d=0 s=1",
                           i, res_valid, res_illegal, res_data, res_src);
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    a_valid = 1'b1; a_instr = 47'h10; a_op1 = 32'hFF00; a_op2 = 32'h0FF0; a_tag = 5'd6;
    tick();
    res_ready = 1'b0;
    b_valid = 1'b1; b_instr = 47'h1; b_op1 = 32'd8; b_op2 = 32'd9; b_tag = 5'd7;
    #1;
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pending got=%b want=1", res_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_ready got=%b want=00", {a_ready, b_ready});
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({res_valid, busy_cnt} !== 17'd0) begin
      errors++; $display("FAIL mid_flush got v=%0b busy=%0d want v=0 busy=0", res_valid, busy_cnt);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_first_grant got=%b want=10", {a_ready, b_ready});
    end
    tick();
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errors++; $display("FAIL mid_second_grant got=%b want=01", {a_ready, b_ready});
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || last_ga) begin
        a_valid = ($urandom_range(0, 9) < 6);
        a_instr = rand_op(); a_op1 = $urandom; a_op2 = $urandom; a_tag = 5'($urandom);
      end
      if (!b_valid || last_gb) begin
        b_valid = ($urandom_range(0, 9) < 6);
        b_instr = rand_op(); b_op1 = $urandom; b_op2 = $urandom; b_tag = 5'($urandom);
      end
      res_ready = ($urandom_range(0, 9) < 7);
      #1;
      predict();
      checks++;
      if ({a_ready, b_ready} !== {exp_ga, exp_gb}) begin
        errors++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, {a_ready, b_ready}, {exp_ga, exp_gb});
      end
      tick();
      checks++;
      if ({res_valid, res_data, res_src, res_tag, res_illegal} !== {m_valid, m_data, m_src, m_tag, m_ill}) begin
        errors++; $display("FAIL rand_res n=%0d got=%h want=%h", n,
                           {res_valid, res_data, res_src, res_tag, res_illegal},
                           {m_valid, m_data, m_src, m_tag, m_ill});
      end
      checks++;
      if (busy_cnt !== 16'(m_busy)) begin
        errors++; $display("FAIL rand_busy n=%0d got=%0d want=%0d", n, busy_cnt, m_busy);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    a_valid = 1'b0; a_instr = '0; a_op1 = '0; a_op2 = '0; a_tag = '0;
    b_valid = 1'b0; b_instr = '0; b_op1 = '0; b_op2 = '0; b_tag = '0;
    test_reset();
    test_single_a();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
